// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding and
// its saturating update.
package bp_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e res;
    res = ctr;
    case (ctr)
      CtrSnt:  res = taken ? CtrWnt : CtrSnt;
      CtrWnt:  res = taken ? CtrWt  : CtrSnt;
      CtrWt:   res = taken ? CtrSt  : CtrWnt;
      CtrSt:   res = taken ? CtrSt  : CtrWt;
      default: res = ctr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 16-bit event counter that sticks at all-ones; synchronous active-low reset.
module bp_sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, looked up in IF and trained from ID.
// Define BP_STATS_EN to add the lookup/hit/mispredict statistics outputs.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lookup_en,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_jump,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [15:0]     stat_lookups,
  output logic [15:0]     stat_hits,
  output logic [15:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_e             ctr;
  } btb_entry_t;

  localparam btb_entry_t ResetEntry = '{valid: 1'b0, tag: '0, target: '0, ctr: CtrWnt};

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  btb_entry_t       lk_entry, upd_old, upd_new;
  logic             upd_hit, upd_taken_eff, upd_we;

  // Word-aligned PCs: the two byte-offset bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[PC_W-1:IDX_W+2];
  assign lk_entry = btb_q[lk_idx];

  assign pred_hit    = lookup_en & lk_entry.valid & (lk_entry.tag == lk_tag);
  assign pred_taken  = pred_hit & lk_entry.ctr[1];
  assign pred_target = pred_taken ? lk_entry.target : '0;

  assign upd_idx       = upd_pc[IDX_W+1:2];
  assign upd_tag       = upd_pc[PC_W-1:IDX_W+2];
  assign upd_old       = btb_q[upd_idx];
  assign upd_hit       = upd_old.valid & (upd_old.tag == upd_tag);
  assign upd_taken_eff = upd_taken | upd_jump;

  assign mispredict = upd_valid & ((upd_taken_eff != upd_pred_taken) |
                                   (upd_taken_eff & (upd_target != upd_pred_target)));

  always_comb begin
    upd_new = upd_old;
    upd_we  = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_jump) begin
          upd_new.ctr    = CtrSt;
          upd_new.target = upd_target;
        end else begin
          upd_new.ctr = ctr_next(upd_old.ctr, upd_taken);
          if (upd_taken) begin
            upd_new.target = upd_target;
          end
        end
      end else if (upd_taken_eff) begin
        // Miss on a taken branch/jump evicts whatever occupies the slot.
        upd_we         = 1'b1;
        upd_new.valid  = 1'b1;
        upd_new.tag    = upd_tag;
        upd_new.target = upd_target;
        if (upd_jump) begin
          upd_new.ctr = CtrSt;
        end else begin
          upd_new.ctr = CtrWt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i] <= ResetEntry;
      end
    end else if (upd_we) begin
      btb_q[upd_idx] <= upd_new;
    end
  end

`ifdef BP_STATS_EN
  bp_sat_counter u_stat_lookups (
    .clk   (clk),
    .reset (reset),
    .inc   (lookup_en),
    .count (stat_lookups)
  );

  bp_sat_counter u_stat_hits (
    .clk   (clk),
    .reset (reset),
    .inc   (pred_hit),
    .count (stat_hits)
  );

  bp_sat_counter u_stat_mispredicts (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (stat_mispredicts)
  );
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural BTB model.
module tb_branch_predictor;

  localparam int PC_W    = 8;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            lookup_en;
  logic [PC_W-1:0] lookup_pc;
  logic            pred_hit, pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid, upd_jump, upd_taken, upd_pred_taken;
  logic [PC_W-1:0] upd_pc, upd_target, upd_pred_target;
  logic            mispredict;
`ifdef BP_STATS_EN
  logic [15:0]     stat_lookups, stat_hits, stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: one record per slot, counter as an integer 0..3.
  int m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_target[ENTRIES];
  int m_ctr   [ENTRIES];
  int m_lookups, m_hits, m_mis;
  bit started = 1'b0;
  logic rst_val;

  branch_predictor #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_en       (lookup_en),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_jump        (upd_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input int pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int tag_of(input int pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit exp_hit();
    int s;
    s = slot(int'(lookup_pc));
    return lookup_en && (m_valid[s] != 0) && (m_tag[s] == tag_of(int'(lookup_pc)));
  endfunction

  function automatic bit exp_taken();
    return exp_hit() && (m_ctr[slot(int'(lookup_pc))] >= 2);
  endfunction

  function automatic int exp_target();
    return exp_taken() ? m_target[slot(int'(lookup_pc))] : 0;
  endfunction

  function automatic bit exp_mis();
    bit tk;
    tk = upd_taken || upd_jump;
    return upd_valid && ((tk != upd_pred_taken) || (tk && (upd_target != upd_pred_target)));
  endfunction

  // Model advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    int s, t;
    bit tk, hit;
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_lookups = 0;
      m_hits    = 0;
      m_mis     = 0;
      started   = 1'b1;
    end else begin
      if (lookup_en && m_lookups < 65535) m_lookups++;
      if (exp_hit() && m_hits < 65535) m_hits++;
      if (exp_mis() && m_mis < 65535) m_mis++;
      if (upd_valid) begin
        s   = slot(int'(upd_pc));
        t   = tag_of(int'(upd_pc));
        tk  = upd_taken || upd_jump;
        hit = (m_valid[s] != 0) && (m_tag[s] == t);
        if (hit) begin
          if (upd_jump) begin
            m_ctr[s] = 3;
            m_target[s] = int'(upd_target);
          end else if (upd_taken) begin
            m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
            m_target[s] = int'(upd_target);
          end else begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          end
        end else if (tk) begin
          m_valid[s]  = 1;
          m_tag[s]    = t;
          m_target[s] = int'(upd_target);
          m_ctr[s]    = upd_jump ? 3 : 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_hit", {31'b0, pred_hit}, {31'b0, exp_hit()});
      chk("model_taken", {31'b0, pred_taken}, {31'b0, exp_taken()});
      chk("model_target", {24'b0, pred_target}, exp_target());
      chk("model_mispredict", {31'b0, mispredict}, {31'b0, exp_mis()});
`ifdef BP_STATS_EN
      chk("model_stat_lookups", {16'b0, stat_lookups}, m_lookups);
      chk("model_stat_hits", {16'b0, stat_hits}, m_hits);
      chk("model_stat_mispredicts", {16'b0, stat_mispredicts}, m_mis);
`endif
    end
  end

  // One cycle: apply inputs after the edge, return at the following falling edge.
  task automatic cyc(input logic le, input int lpc, input logic uv, input int upc,
                     input logic uj, input logic ut, input int utg,
                     input logic upt, input int uptg);
    @(posedge clk);
    #1;
    reset           = rst_val;
    lookup_en       = le;
    lookup_pc       = lpc[PC_W-1:0];
    upd_valid       = uv;
    upd_pc          = upc[PC_W-1:0];
    upd_jump        = uj;
    upd_taken       = ut;
    upd_target      = utg[PC_W-1:0];
    upd_pred_taken  = upt;
    upd_pred_target = uptg[PC_W-1:0];
    @(negedge clk);
  endtask

  task automatic look(input int lpc);
    cyc(1'b1, lpc, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic chk_pred(input string name, input bit h, input bit t, input int tg);
    chk({name, "_hit"}, {31'b0, pred_hit}, {31'b0, h});
    chk({name, "_taken"}, {31'b0, pred_taken}, {31'b0, t});
    chk({name, "_target"}, {24'b0, pred_target}, tg);
  endtask

  initial begin
    rst_val = 1'b0;
    reset = 1'b0;
    lookup_en = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    rst_val = 1'b1;

    look('h10);
    chk_pred("reset_lookup", 1'b0, 1'b0, 0);
    // Train 0x10 taken; lookup in the same cycle still sees the old entry.
    cyc(1'b1, 'h10, 1'b1, 'h10, 1'b0, 1'b1, 'h40, 1'b0, 0);
    chk("train_mispredict", {31'b0, mispredict}, 32'd1);
    chk("train_same_cycle_hit", {31'b0, pred_hit}, 32'd0);
    cyc(1'b1, 'h10, 1'b1, 'h10, 1'b0, 1'b0, 0, 1'b1, 'h40);
    chk_pred("trained", 1'b1, 1'b1, 'h40);
    chk("nt1_mispredict", {31'b0, mispredict}, 32'd1);
    cyc(1'b1, 'h10, 1'b1, 'h10, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_pred("after_nt1", 1'b1, 1'b0, 0);
    chk("nt2_mispredict", {31'b0, mispredict}, 32'd0);
    cyc(1'b1, 'h10, 1'b1, 'h10, 1'b0, 1'b1, 'h40, 1'b0, 0);
    look('h10);
    chk_pred("ctr_01_after_taken", 1'b1, 1'b0, 0);

    // Aliasing: 0x10 and 0x50 share slot 4.
    cyc(1'b1, 'h50, 1'b1, 'h10, 1'b0, 1'b1, 'h40, 1'b0, 0);
    chk_pred("alias_miss", 1'b0, 1'b0, 0);
    cyc(1'b1, 'h10, 1'b1, 'h50, 1'b1, 1'b0, 'h80, 1'b0, 0);
    chk_pred("pre_evict", 1'b1, 1'b1, 'h40);
    chk("jump_mispredict", {31'b0, mispredict}, 32'd1);
    look('h10);
    chk_pred("evicted", 1'b0, 1'b0, 0);
    cyc(1'b1, 'h50, 1'b1, 'h50, 1'b1, 1'b0, 'h80, 1'b1, 'h80);
    chk_pred("jump_entry", 1'b1, 1'b1, 'h80);
    chk("correct_pred", {31'b0, mispredict}, 32'd0);
    cyc(1'b1, 'h50, 1'b1, 'h50, 1'b1, 1'b0, 'h80, 1'b1, 'h84);
    chk("wrong_target", {31'b0, mispredict}, 32'd1);

    // Read-before-write on a fresh slot, then lookup_en gating and stall updates.
    cyc(1'b1, 'h20, 1'b1, 'h20, 1'b0, 1'b1, 'h60, 1'b0, 0);
    chk_pred("rbw_same_cycle", 1'b0, 1'b0, 0);
    look('h20);
    chk_pred("rbw_next_cycle", 1'b1, 1'b1, 'h60);
    cyc(1'b0, 'h20, 1'b1, 'h30, 1'b0, 1'b1, 'h70, 1'b0, 0);
    chk_pred("lookup_disabled", 1'b0, 1'b0, 0);
    look('h30);
    chk_pred("stall_update", 1'b1, 1'b1, 'h70);

    // Mid-stream reset discards the pending update as well.
    rst_val = 1'b0;
    cyc(1'b1, 'h20, 1'b1, 'h24, 1'b0, 1'b1, 'h64, 1'b0, 0);
    rst_val = 1'b1;
    look('h20);
    chk_pred("post_reset_20", 1'b0, 1'b0, 0);
    look('h24);
    chk_pred("post_reset_24", 1'b0, 1'b0, 0);

    // Mixed traffic over a few aliasing PCs, checked by the model each cycle.
    for (int i = 0; i < 300; i++) begin
      int pcs[6];
      pcs = '{'h10, 'h50, 'h20, 'h60, 'h14, 'hD0};
      cyc($urandom_range(0, 3) != 0, pcs[$urandom_range(0, 5)],
          $urandom_range(0, 1) == 1, pcs[$urandom_range(0, 5)],
          $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
          4 * $urandom_range(0, 63), $urandom_range(0, 1) == 1,
          4 * $urandom_range(0, 63));
    end

`ifdef BP_STATS_EN
    rst_val = 1'b0;
    look('h10);
    rst_val = 1'b1;
    look('h10);
    chk("stats_cleared_lookups", {16'b0, stat_lookups}, 32'd0);
    chk("stats_cleared_mis", {16'b0, stat_mispredicts}, 32'd0);
    for (int i = 0; i < 70000; i++) begin
      cyc(1'b1, 'h10, (i % 7) == 0, 'h10, 1'b0, (i % 3) == 0, 'h40, 1'b1, 'h40);
    end
    chk("stats_saturated", {16'b0, stat_lookups}, 32'h0000FFFF);
    rst_val = 1'b0;
    look('h10);
    rst_val = 1'b1;
    look('h10);
    chk("stats_reset_lookups", {16'b0, stat_lookups}, 32'd0);
    chk("stats_reset_hits", {16'b0, stat_hits}, 32'd0);
    chk("stats_reset_mis", {16'b0, stat_mispredicts}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, placed in IF beside the PC register.
- Predicts next-PC for branches and jumps at fetch, so the pipeline no longer flushes on every taken branch resolved in ID.
- Trained from ID once the branch or jump outcome is known.
- Reports mispredictions so the pipeline flushes only when the prediction was wrong.

Parameters:
PC_W, 8, program-counter width in bits (byte address, word aligned)
ENTRIES, 16, BTB entries; power of two, 2..256
IDX_W, log2(ENTRIES), derived index width; not overridable
TAG_W, PC_W-IDX_W-2, derived tag width; must be >= 1

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
lookup_en  in  1  fetch is advancing; 0 during stall
lookup_pc  in  PC_W  current fetch PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predict taken
pred_target  out  PC_W  predicted target; 0 when pred_taken=0
upd_valid  in  1  resolved branch/jump in ID this cycle
upd_pc  in  PC_W  PC of the resolved instruction
upd_jump  in  1  unconditional jump
upd_taken  in  1  actual outcome (forced 1 when upd_jump)
upd_target  in  PC_W  actual target
upd_pred_taken  in  1  prediction made at fetch (carried through IF/ID)
upd_pred_target  in  PC_W  predicted target carried through IF/ID
mispredict  out  1  flush request for the resolved instruction

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0].
- Reset while reset=0 at a clk edge, including mid-operation:
  - all valid=0, ctr=2'b01.
  - stat counters = 0.
  - pending update in that cycle is discarded.
- Lookup (combinational from registered table, zero latency):
  - pred_hit = lookup_en & valid & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_target = entry target when pred_taken, else 0.
  - lookup_en=0 forces all three outputs to 0.
- Mispredict (combinational):
  - mispredict = upd_valid & ((taken != upd_pred_taken) | (taken & upd_target != upd_pred_target)).
  - taken = upd_taken | upd_jump.
- Update (registered; visible to lookups the cycle after the edge):
  - hit, jump: ctr=2'b11, target=upd_target.
  - hit, taken: ctr saturating increment (11 stays 11), target=upd_target.
  - hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - miss, taken or jump: allocate and overwrite victim; valid=1, tag, target; ctr=2'b10 for branch, 2'b11 for jump.
  - miss, not taken: no state change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-before-write).
- Aliasing: PCs sharing an index but differing in tag evict each other. No associativity.
- upd_valid is independent of lookup_en; updates apply during fetch stalls.

Optional Feature:
BP_STATS_EN
- Defined: adds outputs stat_lookups, stat_hits, stat_mispredicts (each 16 bits).
  - Increment respectively on lookup_en, pred_hit, mispredict.
  - Saturate at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - ctr_next(ctr, taken) saturating function.
  - btb entry struct (valid, tag, target, ctr), parametrised via widths.
- One natural sub-module, bp_sat_counter: 16-bit saturating event counter, instantiated three times under BP_STATS_EN.
- Table and update logic remain in branch_predictor.

Test Plan:
- Reset, then lookup_pc=0x10, lookup_en=1 -> pred_hit=0, pred_taken=0, pred_target=0.
- Train: upd pc=0x10 taken target=0x40, upd_pred_taken=0 -> mispredict=1. Next cycle lookup 0x10 -> hit=1, taken=1, target=0x40.
- Two not-taken updates at 0x10 (ctr 10->01->00):
  - after the first, lookup 0x10 -> hit=1, taken=0.
  - after the second, a taken update moves ctr to 01 -> still taken=0.
- Aliasing (ENTRIES=16): train 0x10 taken -> 0x40, then lookup 0x50 -> hit=0. Train 0x50 jump -> 0x80 -> lookup 0x10 hit=0, lookup 0x50 taken=1, target=0x80.
- Same-cycle: update 0x20 taken -> 0x60 while looking up 0x20 -> that cycle hit=0; next cycle hit=1, target=0x60. Assert reset=0 for one cycle mid-stream -> next lookup hit=0.
- BP_STATS_EN: 70000 cycles with lookup_en=1 -> stat_lookups=16'hFFFF (saturated); mispredict count matches scoreboard; counters 0 after reset.
